// File: rtl/ps2_key_decoder.sv
// ============================================================================
//  Module      : ps2_key_decoder
//  Description : PS/2 keyboard deframer; folds E0/F0 prefixes into one
//                11-bit {toggle, pressed, extended, code} key event word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 12000
) (
    input  logic        clk_12,
    input  logic        RESET_L,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    localparam logic [7:0]    FL_LAST = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYC - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic          clk_s1, clk_s2, dat_s1, dat_s2;
    logic          filt_clk, filt_clk_d;
    logic [7:0]    filt_cnt;
    logic          fall;
    logic [1:0]    state;
    logic [2:0]    bitcnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tcnt;
    logic          ext, rel;

    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Filtered clock moves only after FILTER_LEN consecutive samples of the new level.
    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            filt_cnt   <= 8'd0;
        end else begin
            filt_clk_d <= filt_clk;
            if (clk_s2 == filt_clk) begin
                filt_cnt <= 8'd0;
            end else if (filt_cnt == FL_LAST) begin
                filt_clk <= clk_s2;
                filt_cnt <= 8'd0;
            end else begin
                filt_cnt <= filt_cnt + 8'd1;
            end
        end
    end

    assign fall = filt_clk_d & ~filt_clk;
    assign busy = (state != IDLE);

    always_ff @(posedge clk_12 or negedge RESET_L) begin
        if (!RESET_L) begin
            state     <= IDLE;
            bitcnt    <= 3'd0;
            shreg     <= 8'd0;
            par       <= 1'b0;
            tcnt      <= '0;
            ext       <= 1'b0;
            rel       <= 1'b0;
            ps2_key   <= 11'd0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (state == IDLE || fall) begin
                tcnt <= '0;
            end else begin
                tcnt <= tcnt + 1'b1;
            end

            if (fall) begin
                case (state)
                    IDLE: begin
                        if (!dat_s2) begin
                            state  <= DATA;
                            bitcnt <= 3'd0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shreg  <= {dat_s2, shreg[7:1]};
                        bitcnt <= bitcnt + 3'd1;
                        if (bitcnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= dat_s2;
                        state <= STOP;
                    end
                    default: begin
                        state <= IDLE;
                        if (dat_s2 && (^{shreg, par})) begin
                            if (shreg == 8'hE0) begin
                                ext <= 1'b1;
                            end else if (shreg == 8'hF0) begin
                                rel <= 1'b1;
                            end else if (shreg == 8'hE1) begin
                                ext <= 1'b0;
                                rel <= 1'b0;
                            end else begin
                                ps2_key <= {~ps2_key[10], ~rel, ext, shreg};
                                ext     <= 1'b0;
                                rel     <= 1'b0;
                            end
                        end else begin
                            frame_err <= 1'b1;
                            ext       <= 1'b0;
                            rel       <= 1'b0;
                        end
                    end
                endcase
            end else if (state != IDLE && tcnt == TO_LAST) begin
                // Keyboard stalled mid-frame: drop partial byte and any pending prefix.
                state     <= IDLE;
                frame_err <= 1'b1;
                ext       <= 1'b0;
                rel       <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
// ============================================================================
//  Module      : tb_ps2_key_decoder
//  Description : Directed self-checking bench for ps2_key_decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ps2_key_decoder;

    localparam int HALF = 30;

    logic        clk_12;
    logic        RESET_L;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    int busy_hi  = 0;
    int err_base;

    ps2_key_decoder #(.FILTER_LEN(8), .TIMEOUT_CYC(12000)) dut (
        .clk_12   (clk_12),
        .RESET_L  (RESET_L),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .ps2_key  (ps2_key),
        .frame_err(frame_err),
        .busy     (busy)
    );

    initial clk_12 = 1'b0;
    always #5 clk_12 = ~clk_12;

    always @(posedge clk_12) begin
        if (frame_err) err_cnt <= err_cnt + 1;
        if (busy)      busy_hi <= busy_hi + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk_12);
        ps2_data = b;
        repeat (HALF) @(negedge clk_12);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk_12);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        repeat (HALF) @(negedge clk_12);
    endtask

    initial begin
        RESET_L  = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        repeat (5) @(negedge clk_12);
        check("reset_key", 32'(ps2_key), 32'h000);
        check("reset_err", 32'(frame_err), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        RESET_L = 1'b1;
        repeat (20) @(negedge clk_12);

        // A make
        err_base = err_cnt;
        send_frame(8'h1C, 1'b0);
        check("make_1c", 32'(ps2_key), 32'h61C);
        check("make_1c_noerr", 32'(err_cnt - err_base), 32'd0);

        // Extended release: E0 F0 75
        send_frame(8'hE0, 1'b0);
        check("e0_no_event", 32'(ps2_key), 32'h61C);
        send_frame(8'hF0, 1'b0);
        check("f0_no_event", 32'(ps2_key), 32'h61C);
        send_frame(8'h75, 1'b0);
        check("ext_release_75", 32'(ps2_key), 32'h175);

        // Parity error after E0 clears the prefix
        err_base = err_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h29, 1'b1);
        check("parity_err_pulse", 32'(err_cnt - err_base), 32'd1);
        check("parity_err_key", 32'(ps2_key), 32'h175);
        send_frame(8'h6B, 1'b0);
        check("prefix_dropped_6b", 32'(ps2_key), 32'h66B);

        // Timeout after 4 data bits
        err_base = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        check("timeout_busy_mid", 32'(busy), 32'h1);
        repeat (11900) @(negedge clk_12);
        check("timeout_not_yet", 32'(err_cnt - err_base), 32'd0);
        repeat (200) @(negedge clk_12);
        check("timeout_busy_low", 32'(busy), 32'h0);
        check("timeout_err_pulse", 32'(err_cnt - err_base), 32'd1);
        send_frame(8'h16, 1'b0);
        check("after_timeout_16", 32'(ps2_key), 32'h216);

        // Short glitch in IDLE
        err_base = err_cnt;
        busy_hi  = 0;
        @(negedge clk_12);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk_12);
        ps2_clk = 1'b1;
        repeat (50) @(negedge clk_12);
        check("glitch_busy", 32'(busy_hi), 32'd0);
        check("glitch_noerr", 32'(err_cnt - err_base), 32'd0);
        check("glitch_key", 32'(ps2_key), 32'h216);

        // Reset while in PARITY state
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(1'b0);
        @(negedge clk_12);
        check("pre_reset_busy", 32'(busy), 32'h1);
        RESET_L = 1'b0;
        #1;
        check("reset_mid_key", 32'(ps2_key), 32'h000);
        check("reset_mid_busy", 32'(busy), 32'h0);
        repeat (3) @(negedge clk_12);
        RESET_L = 1'b1;
        repeat (20) @(negedge clk_12);
        err_base = err_cnt;
        send_frame(8'h05, 1'b0);
        check("post_reset_05", 32'(ps2_key), 32'h605);
        check("post_reset_noerr", 32'(err_cnt - err_base), 32'd0);

        // Typematic repeat toggles bit 10
        send_frame(8'h05, 1'b0);
        check("typematic_05", 32'(ps2_key), 32'h205);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
